rettangolo_mobile: RTL and testbench
====================================

Name: rettangolo_mobile

Overview:
Parametrised moving rectangle/frame object for the 1280x720 pixel pipeline. It holds its own centre position and direction registers and advances once per frame on FRAME_TICK. Movement either bounces off the screen edges or wraps horizontally. It also answers the per-pixel hit test, filled or frame outline, with a registered output.

Parameters:
ALTEZZA, 100, object height in pixels (even)
LARGHEZZA, 100, object width in pixels (even)
SPESSORE, 6, frame thickness term; inner box is (ALTEZZA-SPESSORE) x (LARGHEZZA-SPESSORE)
H, 1280, horizontal screen size
V, 720, vertical screen size
VEL_X, 4, horizontal step per frame, 1..LARGHEZZA/2
VEL_Y, 2, vertical step per frame, 1..ALTEZZA/2
WRAP_X, 0, 0 = bounce on left/right edges; 1 = horizontal wrap modulo H

Ports:
CLK  in  1  pixel clock
RST_N  in  1  asynchronous active-low reset
ENABLE  in  1  motion enable
FRAME_TICK  in  1  one-cycle pulse per frame (vblank start)
LOAD  in  1  synchronous load of position and direction
X_INIT  in  11  centre X to load
Y_INIT  in  11  centre Y to load
DIR_INIT  in  2  {dir_y, dir_x} to load; 1 = increasing coordinate
MODO  in  1  0 = filled rectangle, 1 = frame only
X_CONTROLLO  in  11  pixel X under test
Y_CONTROLLO  in  11  pixel Y under test
CONFERMA  out  1  registered hit for the pixel presented one cycle earlier
X_POS  out  11  current centre X
Y_POS  out  11  current centre Y
DIR_X  out  1  current X direction
DIR_Y  out  1  current Y direction
BORDO  out  1  one-cycle pulse when any bounce occurs

Behaviour:
- Reset values: X_POS=H/2 (640), Y_POS=V/2 (360), DIR_X=1, DIR_Y=1, CONFERMA=0, BORDO=0, FSM state FERMO.
- FSM states and transitions:
  - FERMO: if ENABLE=1, go to ATTESA.
  - ATTESA: if ENABLE=0, go to FERMO. Else if FRAME_TICK=1, go to AGG_X.
  - AGG_X: X_POS and DIR_X take their new values at the end of this cycle; go to AGG_Y.
  - AGG_Y: Y_POS and DIR_Y take their new values at the end of this cycle; go to ATTESA, or FERMO if ENABLE=0.
- FRAME_TICK arriving in AGG_X or AGG_Y is ignored; no tick is queued.
- ENABLE falling during AGG_X completes AGG_Y before stopping.
- Update rule, 12-bit unsigned arithmetic, no overflow:
  - Increasing X: n=X+VEL_X. If n+LARGHEZZA/2 > H-1, then X=H-1-LARGHEZZA/2, DIR_X flips, BORDO=1.
  - Decreasing X: if X < LARGHEZZA/2+VEL_X, then X=LARGHEZZA/2, DIR_X flips, BORDO=1. Else X=X-VEL_X.
  - Y axis: same rule with V, ALTEZZA, VEL_Y. Y always bounces.
  - WRAP_X=1: X=(X±VEL_X) mod H, no X bounce, DIR_X never changes.
- BORDO is high for exactly the one cycle after the AGG_X or AGG_Y that bounced. A bounce on both axes produces two separate pulses.
- LOAD has priority over every state and over FRAME_TICK in the same cycle:
  - Next cycle: X_POS=X_INIT, Y_POS=Y_INIT, {DIR_Y,DIR_X}=DIR_INIT.
  - FSM goes to ATTESA if ENABLE=1, else FERMO. An update in progress is abandoned.
  - With WRAP_X=0, X_INIT is clamped to [LARGHEZZA/2, H-1-LARGHEZZA/2].
  - Y_INIT is always clamped to [ALTEZZA/2, V-1-ALTEZZA/2].
  - With WRAP_X=1, X_INIT >= H loads X_INIT-H.
- Hit test, evaluated on the current X_POS/Y_POS and registered into CONFERMA (latency 1 cycle):
  - dy=|Y_CONTROLLO-Y_POS|.
  - dx=|X_CONTROLLO-X_POS|; with WRAP_X=1, dx=min(d, H-d) where d=|X_CONTROLLO-X_POS|.
  - esterno = dx < LARGHEZZA/2 and dy < ALTEZZA/2 (strict).
  - interno = dx < (LARGHEZZA-SPESSORE)/2 and dy < (ALTEZZA-SPESSORE)/2.
  - CONFERMA_next = esterno if MODO=0; esterno and not interno if MODO=1.
- A position change and a hit test in the same cycle: the test uses the pre-update position.
- Asynchronous reset mid-update clears all registers immediately; no partial update survives.

Test Plan:
- Reset, then probe (640,360) with MODO=0 -> CONFERMA=1 one cycle later. Same probe with MODO=1 -> CONFERMA=0. Probe (592,360) with MODO=1 -> CONFERMA=1 (dx=48: 48<50, not <47). Probe (590,360) -> 0.
- LOAD X=1227 Y=360 DIR=11, ENABLE=1, FRAME_TICK -> after AGG_X: X_POS=1229, DIR_X=0, BORDO pulse. After AGG_Y: Y_POS=362, DIR_Y=1.
- LOAD Y=51 DIR_Y=0, FRAME_TICK -> Y_POS=50, DIR_Y=1, BORDO pulse. Next frame -> Y_POS=52.
- WRAP_X=1: LOAD X=1278 DIR_X=1, FRAME_TICK -> X_POS=2, no BORDO. LOAD X=10, probe (1270,360) -> CONFERMA=1 (wrapped dx=20).
- LOAD and FRAME_TICK in the same cycle -> loaded values appear, FSM in ATTESA, no update that frame. FRAME_TICK during AGG_Y -> ignored, exactly one step per frame.
- Assert RST_N low while in AGG_X -> outputs immediately return to 640/360/1/1/0/0. ENABLE=0 -> FRAME_TICK causes no motion.

Source files
------------

// File: rtl/rettangolo_mobile.sv
// -----------------------------------------------------------------------------
// rettangolo_mobile
// Moving rectangle / frame object for a 1280x720 pixel pipeline.
// Holds its own centre position and direction, advances one step per frame
// (X in one cycle, Y in the following cycle) and answers a registered
// per-pixel hit test, either as a filled box or as a frame outline.
//
// Ports:
//   CLK, RST_N            pixel clock, asynchronous active-low reset
//   ENABLE                motion enable
//   FRAME_TICK            one-cycle pulse per frame
//   LOAD                  load X_INIT/Y_INIT/DIR_INIT (highest priority)
//   X_INIT, Y_INIT        centre to load (clamped / wrapped on load)
//   DIR_INIT              {dir_y, dir_x} to load, 1 = increasing coordinate
//   MODO                  0 = filled rectangle, 1 = frame only
//   X_CONTROLLO,
//   Y_CONTROLLO           pixel under test
//   CONFERMA              hit for the pixel presented one cycle earlier
//   X_POS, Y_POS          current centre
//   DIR_X, DIR_Y          current directions
//   BORDO                 one-cycle pulse after an update that bounced
// -----------------------------------------------------------------------------
module rettangolo_mobile #(
    parameter int ALTEZZA   = 100,
    parameter int LARGHEZZA = 100,
    parameter int SPESSORE  = 6,
    parameter int H         = 1280,
    parameter int V         = 720,
    parameter int VEL_X     = 4,
    parameter int VEL_Y     = 2,
    parameter int WRAP_X    = 0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        ENABLE,
    input  logic        FRAME_TICK,
    input  logic        LOAD,
    input  logic [10:0] X_INIT,
    input  logic [10:0] Y_INIT,
    input  logic [1:0]  DIR_INIT,
    input  logic        MODO,
    input  logic [10:0] X_CONTROLLO,
    input  logic [10:0] Y_CONTROLLO,
    output logic        CONFERMA,
    output logic [10:0] X_POS,
    output logic [10:0] Y_POS,
    output logic        DIR_X,
    output logic        DIR_Y,
    output logic        BORDO
);

    localparam logic [11:0] HALF_W  = 12'(LARGHEZZA / 2);
    localparam logic [11:0] HALF_H  = 12'(ALTEZZA / 2);
    localparam logic [11:0] INNER_W = 12'((LARGHEZZA - SPESSORE) / 2);
    localparam logic [11:0] INNER_H = 12'((ALTEZZA - SPESSORE) / 2);
    localparam logic [11:0] X_MAX   = 12'(H - 1 - LARGHEZZA / 2);
    localparam logic [11:0] Y_MAX   = 12'(V - 1 - ALTEZZA / 2);
    localparam logic [11:0] H_LAST  = 12'(H - 1);
    localparam logic [11:0] V_LAST  = 12'(V - 1);
    localparam logic [11:0] H_SIZE  = 12'(H);
    localparam logic [11:0] STEP_X  = 12'(VEL_X);
    localparam logic [11:0] STEP_Y  = 12'(VEL_Y);

    typedef enum logic [1:0] {FERMO, ATTESA, AGG_X, AGG_Y} state_t;

    state_t      state_reg, state_next;
    logic [10:0] x_reg, x_next;
    logic [10:0] y_reg, y_next;
    logic        dir_x_reg, dir_x_next;
    logic        dir_y_reg, dir_y_next;
    logic        bordo_reg, bordo_next;
    logic        conferma_reg, conferma_next;

    // One-frame step candidates, computed from the current position.
    logic [11:0] x_step, y_step;
    logic        x_flip, y_flip;
    // Load values after clamp / wrap.
    logic [11:0] x_load, y_load;

    always_comb begin
        x_step = {1'b0, x_reg};
        x_flip = 1'b0;
        if (WRAP_X != 0) begin
            if (dir_x_reg) begin
                x_step = {1'b0, x_reg} + STEP_X;
                if (x_step >= H_SIZE) begin
                    x_step = x_step - H_SIZE;
                end
            end else if ({1'b0, x_reg} < STEP_X) begin
                x_step = {1'b0, x_reg} + H_SIZE - STEP_X;
            end else begin
                x_step = {1'b0, x_reg} - STEP_X;
            end
        end else if (dir_x_reg) begin
            if ({1'b0, x_reg} + STEP_X + HALF_W > H_LAST) begin
                x_step = X_MAX;
                x_flip = 1'b1;
            end else begin
                x_step = {1'b0, x_reg} + STEP_X;
            end
        end else begin
            if ({1'b0, x_reg} < HALF_W + STEP_X) begin
                x_step = HALF_W;
                x_flip = 1'b1;
            end else begin
                x_step = {1'b0, x_reg} - STEP_X;
            end
        end
    end

    always_comb begin
        y_step = {1'b0, y_reg};
        y_flip = 1'b0;
        if (dir_y_reg) begin
            if ({1'b0, y_reg} + STEP_Y + HALF_H > V_LAST) begin
                y_step = Y_MAX;
                y_flip = 1'b1;
            end else begin
                y_step = {1'b0, y_reg} + STEP_Y;
            end
        end else begin
            if ({1'b0, y_reg} < HALF_H + STEP_Y) begin
                y_step = HALF_H;
                y_flip = 1'b1;
            end else begin
                y_step = {1'b0, y_reg} - STEP_Y;
            end
        end
    end

    always_comb begin
        x_load = {1'b0, X_INIT};
        if (WRAP_X != 0) begin
            if (x_load >= H_SIZE) begin
                x_load = x_load - H_SIZE;
            end
        end else if (x_load < HALF_W) begin
            x_load = HALF_W;
        end else if (x_load > X_MAX) begin
            x_load = X_MAX;
        end
        y_load = {1'b0, Y_INIT};
        if (y_load < HALF_H) begin
            y_load = HALF_H;
        end else if (y_load > Y_MAX) begin
            y_load = Y_MAX;
        end
    end

    // Next-state and datapath updates. LOAD overrides everything, including
    // an update half-way through (X moved, Y not yet).
    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        dir_x_next = dir_x_reg;
        dir_y_next = dir_y_reg;
        bordo_next = 1'b0;
        if (LOAD) begin
            x_next     = x_load[10:0];
            y_next     = y_load[10:0];
            dir_x_next = DIR_INIT[0];
            dir_y_next = DIR_INIT[1];
            state_next = ENABLE ? ATTESA : FERMO;
        end else begin
            case (state_reg)
                FERMO: begin
                    if (ENABLE) state_next = ATTESA;
                end
                ATTESA: begin
                    if (!ENABLE)         state_next = FERMO;
                    else if (FRAME_TICK) state_next = AGG_X;
                end
                AGG_X: begin
                    x_next     = x_step[10:0];
                    dir_x_next = dir_x_reg ^ x_flip;
                    bordo_next = x_flip;
                    state_next = AGG_Y;
                end
                AGG_Y: begin
                    y_next     = y_step[10:0];
                    dir_y_next = dir_y_reg ^ y_flip;
                    bordo_next = y_flip;
                    state_next = ENABLE ? ATTESA : FERMO;
                end
                default: state_next = FERMO;
            endcase
        end
    end

    // Hit test on the current (pre-update) position.
    logic [11:0] dx, dx_alt, dy;
    logic        esterno, interno;

    always_comb begin
        dx = (X_CONTROLLO >= x_reg) ? {1'b0, X_CONTROLLO} - {1'b0, x_reg}
                                    : {1'b0, x_reg} - {1'b0, X_CONTROLLO};
        dx_alt = dx;
        if (WRAP_X != 0) begin
            // Distance the other way round the screen.
            dx_alt = (dx < H_SIZE) ? H_SIZE - dx : dx;
            if (dx_alt < dx) dx = dx_alt;
        end
        dy = (Y_CONTROLLO >= y_reg) ? {1'b0, Y_CONTROLLO} - {1'b0, y_reg}
                                    : {1'b0, y_reg} - {1'b0, Y_CONTROLLO};
        esterno       = (dx < HALF_W) && (dy < HALF_H);
        interno       = (dx < INNER_W) && (dy < INNER_H);
        conferma_next = MODO ? (esterno && !interno) : esterno;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg    <= FERMO;
            x_reg        <= 11'(H / 2);
            y_reg        <= 11'(V / 2);
            dir_x_reg    <= 1'b1;
            dir_y_reg    <= 1'b1;
            bordo_reg    <= 1'b0;
            conferma_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            x_reg        <= x_next;
            y_reg        <= y_next;
            dir_x_reg    <= dir_x_next;
            dir_y_reg    <= dir_y_next;
            bordo_reg    <= bordo_next;
            conferma_reg <= conferma_next;
        end
    end

    assign X_POS    = x_reg;
    assign Y_POS    = y_reg;
    assign DIR_X    = dir_x_reg;
    assign DIR_Y    = dir_y_reg;
    assign BORDO    = bordo_reg;
    assign CONFERMA = conferma_reg;

endmodule

// File: tb/tb_rettangolo_mobile.sv
// -----------------------------------------------------------------------------
// tb_rettangolo_mobile
// Drives one bouncing instance (WRAP_X=0) and one wrapping instance (WRAP_X=1)
// from the same stimulus. A reference model computes the expected outputs
// after each clock edge and queues them; a monitor pops and compares on the
// falling edge. A few directed spot checks use hand-derived constants.
// -----------------------------------------------------------------------------
module tb_rettangolo_mobile;

    localparam int HS = 1280, VS = 720;
    localparam int HW = 50, HH = 50, IW = 47, IH = 47;
    localparam int VX = 4, VY = 2;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        ENABLE = 1'b0, FRAME_TICK = 1'b0, LOAD = 1'b0, MODO = 1'b0;
    logic [10:0] X_INIT = '0, Y_INIT = '0, X_CONTROLLO = '0, Y_CONTROLLO = '0;
    logic [1:0]  DIR_INIT = '0;

    logic [1:0]       conf_o, dirx_o, diry_o, bordo_o;
    logic [1:0][10:0] x_o, y_o;

    rettangolo_mobile #(.WRAP_X(0)) u_bounce (
        .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .FRAME_TICK(FRAME_TICK),
        .LOAD(LOAD), .X_INIT(X_INIT), .Y_INIT(Y_INIT), .DIR_INIT(DIR_INIT),
        .MODO(MODO), .X_CONTROLLO(X_CONTROLLO), .Y_CONTROLLO(Y_CONTROLLO),
        .CONFERMA(conf_o[0]), .X_POS(x_o[0]), .Y_POS(y_o[0]),
        .DIR_X(dirx_o[0]), .DIR_Y(diry_o[0]), .BORDO(bordo_o[0])
    );

    rettangolo_mobile #(.WRAP_X(1)) u_wrap (
        .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .FRAME_TICK(FRAME_TICK),
        .LOAD(LOAD), .X_INIT(X_INIT), .Y_INIT(Y_INIT), .DIR_INIT(DIR_INIT),
        .MODO(MODO), .X_CONTROLLO(X_CONTROLLO), .Y_CONTROLLO(Y_CONTROLLO),
        .CONFERMA(conf_o[1]), .X_POS(x_o[1]), .Y_POS(y_o[1]),
        .DIR_X(dirx_o[1]), .DIR_Y(diry_o[1]), .BORDO(bordo_o[1])
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit conf;
        int x;
        int y;
        bit dx;
        bit dy;
        bit bordo;
    } rec_t;

    rec_t sb0[$];
    rec_t sb1[$];

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state per instance (0 = bounce, 1 = wrap).
    int mx[2], my[2];
    bit mdx[2], mdy[2];
    int pending[2];   // 0 idle, 1 = X moves this edge, 2 = Y moves this edge
    bit running[2];   // waiting for a frame tick (enabled)

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    function automatic int clampi(input int a, input int lo, input int hi);
        return (a < lo) ? lo : ((a > hi) ? hi : a);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mx[i] = HS / 2; my[i] = VS / 2;
            mdx[i] = 1'b1; mdy[i] = 1'b1;
            pending[i] = 0; running[i] = 1'b0;
        end
    endtask

    // Advances the model across one rising edge using the inputs currently
    // applied, and queues what the DUT should show after that edge.
    task automatic model_step(input int i);
        rec_t r;
        int   d, ddy, n;
        bit   est, inn;
        d = iabs(int'(X_CONTROLLO) - mx[i]);
        if (i == 1 && HS - d < d) d = HS - d;
        ddy = iabs(int'(Y_CONTROLLO) - my[i]);
        est = (d < HW) && (ddy < HH);
        inn = (d < IW) && (ddy < IH);
        r.conf  = MODO ? (est && !inn) : est;
        r.bordo = 1'b0;
        if (LOAD) begin
            n = int'(X_INIT);
            if (i == 1) mx[i] = (n >= HS) ? n - HS : n;
            else        mx[i] = clampi(n, HW, HS - 1 - HW);
            my[i]  = clampi(int'(Y_INIT), HH, VS - 1 - HH);
            mdx[i] = DIR_INIT[0];
            mdy[i] = DIR_INIT[1];
            pending[i] = 0;
            running[i] = ENABLE;
        end else if (pending[i] == 1) begin
            if (i == 1) begin
                mx[i] = (mx[i] + (mdx[i] ? VX : -VX) + HS) % HS;
            end else if (mdx[i]) begin
                n = mx[i] + VX;
                if (n + HW > HS - 1) begin mx[i] = HS - 1 - HW; mdx[i] = 1'b0; r.bordo = 1'b1; end
                else mx[i] = n;
            end else begin
                if (mx[i] < HW + VX) begin mx[i] = HW; mdx[i] = 1'b1; r.bordo = 1'b1; end
                else mx[i] = mx[i] - VX;
            end
            pending[i] = 2;
        end else if (pending[i] == 2) begin
            if (mdy[i]) begin
                n = my[i] + VY;
                if (n + HH > VS - 1) begin my[i] = VS - 1 - HH; mdy[i] = 1'b0; r.bordo = 1'b1; end
                else my[i] = n;
            end else begin
                if (my[i] < HH + VY) begin my[i] = HH; mdy[i] = 1'b1; r.bordo = 1'b1; end
                else my[i] = my[i] - VY;
            end
            pending[i] = 0;
            running[i] = ENABLE;
        end else if (!running[i]) begin
            running[i] = ENABLE;
        end else if (!ENABLE) begin
            running[i] = 1'b0;
        end else if (FRAME_TICK) begin
            pending[i] = 1;
        end
        r.x = mx[i]; r.y = my[i]; r.dx = mdx[i]; r.dy = mdy[i];
        if (i == 0) sb0.push_back(r);
        else        sb1.push_back(r);
    endtask

    // Apply inputs, take one rising edge, return on the following falling edge.
    task automatic cyc(input bit ld, input bit tk, input bit md, input int xc, input int yc);
        LOAD = ld; FRAME_TICK = tk; MODO = md;
        X_CONTROLLO = 11'(xc); Y_CONTROLLO = 11'(yc);
        @(posedge CLK);
        model_step(0);
        model_step(1);
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    // Monitor: compares every queued expectation on the falling edge.
    int mon_cycle = 0;
    initial begin
        rec_t e;
        forever begin
            @(negedge CLK);
            for (int i = 0; i < 2; i++) begin
                if ((i == 0 && sb0.size() != 0) || (i == 1 && sb1.size() != 0)) begin
                    e = (i == 0) ? sb0.pop_front() : sb1.pop_front();
                    chk($sformatf("conf%0d", i),  32'(conf_o[i]),  32'(e.conf));
                    chk($sformatf("x%0d", i),     32'(x_o[i]),     32'(e.x));
                    chk($sformatf("y%0d", i),     32'(y_o[i]),     32'(e.y));
                    chk($sformatf("dirx%0d", i),  32'(dirx_o[i]),  32'(e.dx));
                    chk($sformatf("diry%0d", i),  32'(diry_o[i]),  32'(e.dy));
                    chk($sformatf("bordo%0d", i), 32'(bordo_o[i]), 32'(e.bordo));
                    if (i == 1) begin
                        mon_cycle++;
                        $display("txn %0d: b(x=%0d y=%0d c=%0b o=%0b) w(x=%0d y=%0d c=%0b o=%0b)",
                                 mon_cycle, x_o[0], y_o[0], conf_o[0], bordo_o[0],
                                 x_o[1], y_o[1], conf_o[1], bordo_o[1]);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int xc, yc, base;
        bit ld, tk;
        model_reset();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_x", 32'(x_o[i]), 640);
            chk("rst_y", 32'(y_o[i]), 360);
            chk("rst_dirs", 32'({diry_o[i], dirx_o[i]}), 3);
            chk("rst_conf_bordo", 32'({conf_o[i], bordo_o[i]}), 0);
        end

        // Hit test at the reset position.
        ENABLE = 1'b0;
        cyc(0, 0, 0, 640, 360); chk("hit_fill_centre", 32'(conf_o[0]), 1);
        cyc(0, 0, 1, 640, 360); chk("hit_frame_centre", 32'(conf_o[0]), 0);
        cyc(0, 0, 1, 592, 360); chk("hit_frame_592", 32'(conf_o[0]), 1);
        cyc(0, 0, 1, 590, 360); chk("hit_frame_590", 32'(conf_o[0]), 0);

        // Right-edge bounce.
        ENABLE = 1'b1; X_INIT = 1227; Y_INIT = 360; DIR_INIT = 2'b11;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("rbounce_x", 32'(x_o[0]), 1229);
        chk("rbounce_dirx", 32'(dirx_o[0]), 0);
        chk("rbounce_bordo", 32'(bordo_o[0]), 1);
        cyc(0, 0, 0, 0, 0);
        chk("rbounce_y", 32'(y_o[0]), 362);
        chk("rbounce_diry", 32'(diry_o[0]), 1);

        // Top-edge bounce then the next frame.
        X_INIT = 640; Y_INIT = 51; DIR_INIT = 2'b00;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("tbounce_y", 32'(y_o[0]), 50);
        chk("tbounce_diry", 32'(diry_o[0]), 1);
        chk("tbounce_bordo", 32'(bordo_o[0]), 1);
        cyc(0, 1, 0, 0, 0);
        idle(2);
        chk("tbounce_next_y", 32'(y_o[0]), 52);

        // Horizontal wrap.
        X_INIT = 1278; Y_INIT = 360; DIR_INIT = 2'b01;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("wrap_x", 32'(x_o[1]), 2);
        chk("wrap_bordo", 32'(bordo_o[1]), 0);
        cyc(0, 0, 0, 0, 0);
        ENABLE = 1'b0; X_INIT = 10;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1270, 360);
        chk("wrap_hit", 32'(conf_o[1]), 1);
        chk("nowrap_miss", 32'(conf_o[0]), 0);

        // LOAD beats FRAME_TICK; a tick during AGG_Y is ignored.
        ENABLE = 1'b1; X_INIT = 400; Y_INIT = 300; DIR_INIT = 2'b11;
        cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("load_tick_x", 32'(x_o[0]), 400);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        idle(3);
        chk("one_step_x", 32'(x_o[0]), 404);
        chk("one_step_y", 32'(y_o[0]), 302);

        // Asynchronous reset while X is being updated.
        X_INIT = 1227; Y_INIT = 360; DIR_INIT = 2'b11;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 1227, 360);
        #1 RST_N = 1'b0;
        #1;
        chk("arst_x", 32'(x_o[0]), 640);
        chk("arst_y", 32'(y_o[0]), 360);
        chk("arst_dirs", 32'({diry_o[0], dirx_o[0]}), 3);
        chk("arst_conf", 32'(conf_o[0]), 0);
        chk("arst_bordo", 32'(bordo_o[0]), 0);
        model_reset();
        RST_N = 1'b1;

        // Disabled: ticks do nothing.
        ENABLE = 1'b0;
        for (int k = 0; k < 4; k++) cyc(0, 1, 0, 0, 0);
        chk("disabled_x", 32'(x_o[0]), 640);

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            ENABLE   = ($urandom_range(0, 9) != 0);
            X_INIT   = 11'($urandom_range(0, 2047));
            Y_INIT   = 11'($urandom_range(0, 2047));
            DIR_INIT = 2'($urandom_range(0, 3));
            ld = ($urandom_range(0, 29) == 0);
            tk = ($urandom_range(0, 5) == 0);
            base = mx[n % 2];
            if ($urandom_range(0, 3) == 0) xc = int'($urandom_range(0, HS - 1));
            else xc = (base + int'($urandom_range(0, 140)) + HS - 70) % HS;
            yc = clampi(my[n % 2] + int'($urandom_range(0, 140)) - 70, 0, VS - 1);
            cyc(ld, tk, 1'($urandom_range(0, 1)), xc, yc);
        end

        @(negedge CLK);
        #1;
        chk("sb_drained", 32'(sb0.size() + sb1.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
